// File: rtl/qeciphy_qpll_reset_ctrl_if.sv
// Status/control bundle between the QPLL reset controller and the QPLL common
// wrapper / channel reset logic.
interface qeciphy_qpll_reset_ctrl_if;
  logic       qplllock_in;
  logic       qpllrefclklost_in;
  logic       reinit_req_in;
  logic       qpllreset_out;
  logic       qpll_ready_out;
  logic [7:0] retry_count_out;
  logic       fault_out;

  modport master (
    output qplllock_in, qpllrefclklost_in, reinit_req_in,
    input  qpllreset_out, qpll_ready_out, retry_count_out, fault_out
  );

  modport slave (
    input  qplllock_in, qpllrefclklost_in, reinit_req_in,
    output qpllreset_out, qpll_ready_out, retry_count_out, fault_out
  );
endinterface

// File: rtl/qeciphy_qpll_reset_ctrl.sv
// QPLL reset sequencer: pulses QPLL reset, qualifies lock, retries on timeout/loss.
// Optional retry-limit FAULT state enabled by `define QECIPHY_QPLL_RETRY_LIMIT_EN.
module qeciphy_qpll_reset_ctrl #(
  parameter int unsigned RESET_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  qeciphy_qpll_reset_ctrl_if.slave qpll
);

  localparam int unsigned MAX_RS  = (STABLE_CYCLES > RESET_CYCLES) ? STABLE_CYCLES : RESET_CYCLES;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first saw lock_s is the first stable cycle.
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 2);
  localparam logic [7:0]    FAIL_CAP     = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_ASSERT,
    REFCLK_WAIT,
    WAIT_LOCK,
    LOCK_STABLE,
    LOCKED,
    FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lock_sync, lost_sync;
  logic          lock_s, lost_s;
  logic          fail_evt, restart, fault_exit, fail_limit;
  logic          reset_q, reset_d, ready_q, ready_d;
  logic [7:0]    retry_q, retry_d, fail_q, fail_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lock_sync <= '0;
      lost_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[0], qpll.qplllock_in};
      lost_sync <= {lost_sync[0], qpll.qpllrefclklost_in};
    end
  end

  assign lock_s = lock_sync[1];
  assign lost_s = lost_sync[1];

`ifdef QECIPHY_QPLL_RETRY_LIMIT_EN
  assign fail_limit = ({1'b0, fail_q} + 9'd1) >= {1'b0, FAIL_CAP};
`else
  assign fail_limit = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= RESET_ASSERT;
      cnt_q   <= '0;
      reset_q <= 1'b1;
      ready_q <= 1'b0;
      retry_q <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reset_q <= reset_d;
      ready_q <= ready_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fail_evt   = 1'b0;
    restart    = 1'b0;
    fault_exit = 1'b0;
    if (state_q == FAULT) begin
      if (qpll.reinit_req_in) begin
        state_d    = RESET_ASSERT;
        fault_exit = 1'b1;
      end
    end else if (lost_s) begin
      state_d = REFCLK_WAIT;
      restart = 1'b1;
    end else if (qpll.reinit_req_in) begin
      state_d = RESET_ASSERT;
      restart = 1'b1;
    end else begin
      case (state_q)
        RESET_ASSERT: if (cnt_q == RESET_LAST) state_d = WAIT_LOCK;
        REFCLK_WAIT:  if (cnt_q == RESET_LAST) state_d = RESET_ASSERT;
        WAIT_LOCK: begin
          if (lock_s)                     state_d  = LOCK_STABLE;
          else if (cnt_q == TIMEOUT_LAST) fail_evt = 1'b1;
        end
        LOCK_STABLE: begin
          if (!lock_s)                   state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = LOCKED;
        end
        LOCKED:  if (!lock_s) fail_evt = 1'b1;
        default: state_d = RESET_ASSERT;
      endcase
    end
    if (fail_evt) state_d = fail_limit ? FAULT : RESET_ASSERT;

    if (restart || (state_d != state_q) || (state_d == LOCKED) || (state_d == FAULT))
      cnt_d = '0;
    else
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    reset_d = (state_d == RESET_ASSERT) || (state_d == REFCLK_WAIT) || (state_d == FAULT);
    ready_d = (state_d == LOCKED);
    retry_d = retry_q;
    if (fail_evt && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;
    fail_d = fail_q;
    if (fault_exit || ((state_d == LOCKED) && (state_q != LOCKED)))
      fail_d = '0;
    else if (fail_evt && (fail_q < FAIL_CAP))
      fail_d = fail_q + 8'd1;
  end

  assign qpll.qpllreset_out   = reset_q;
  assign qpll.qpll_ready_out  = ready_q;
  assign qpll.retry_count_out = retry_q;

`ifdef QECIPHY_QPLL_RETRY_LIMIT_EN
  logic fault_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) fault_q <= 1'b0;
    else        fault_q <= (state_d == FAULT);
  end

  assign qpll.fault_out = fault_q;
`else
  assign qpll.fault_out = 1'b0;
`endif

endmodule

// File: tb/tb_qeciphy_qpll_reset_ctrl.sv
// Directed bench for qeciphy_qpll_reset_ctrl with a deadline-based behavioural
// model compared every cycle plus hand-computed timing expectations.
module tb_qeciphy_qpll_reset_ctrl;
  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 3;
`ifdef QECIPHY_QPLL_RETRY_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  localparam int M_RST = 0, M_LOST = 1, M_ACQ = 2, M_UP = 3, M_FAULT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  qeciphy_qpll_reset_ctrl_if bus ();

  qeciphy_qpll_reset_ctrl #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .qpll  (bus.slave)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phases with absolute deadlines and a lock run length.
  int cyc = 0, mode = M_RST, deadline = 0, lock_run = 0, retries = 0, consec = 0;
  logic lk1 = 0, lk2 = 0, ls1 = 0, ls2 = 0;

  task automatic enter_rst();
    mode     = M_RST;
    deadline = cyc + RC;
  endtask

  always @(posedge clk or posedge rst) begin
    logic lock_s, lost_s, fail;
    cyc++;
    if (rst) begin
      lk1 = 0; lk2 = 0; ls1 = 0; ls2 = 0;
      enter_rst();
      lock_run = 0; retries = 0; consec = 0;
    end else begin
      lock_s = lk2; lost_s = ls2;
      lk2 = lk1; lk1 = bus.qplllock_in;
      ls2 = ls1; ls1 = bus.qpllrefclklost_in;
      fail = 0;
      if (mode == M_FAULT) begin
        if (bus.reinit_req_in) begin consec = 0; enter_rst(); end
      end else if (lost_s) begin
        mode = M_LOST; deadline = cyc + RC;
      end else if (bus.reinit_req_in) begin
        enter_rst();
      end else begin
        case (mode)
          M_RST:  if (cyc == deadline) begin mode = M_ACQ; deadline = cyc + LT; lock_run = 0; end
          M_LOST: if (cyc == deadline) enter_rst();
          M_ACQ: begin
            if (lock_s) begin
              lock_run++;
              if (lock_run == SC) begin mode = M_UP; consec = 0; end
            end else begin
              if (lock_run > 0) deadline = cyc + LT;
              else if (cyc == deadline) fail = 1;
              lock_run = 0;
            end
          end
          M_UP: if (!lock_s) fail = 1;
          default: ;
        endcase
      end
      if (fail) begin
        if (retries < 255) retries++;
        consec++;
        if (LIMIT && consec >= MR) mode = M_FAULT;
        else enter_rst();
      end
    end
  end

  always @(posedge clk) begin
    #3;
    check("cyc_qpllreset", int'(bus.qpllreset_out),
          int'(mode == M_RST || mode == M_LOST || mode == M_FAULT));
    check("cyc_ready", int'(bus.qpll_ready_out), int'(mode == M_UP));
    check("cyc_retry", int'(bus.retry_count_out), retries);
    check("cyc_fault", int'(bus.fault_out), int'(LIMIT && mode == M_FAULT));
  end

  task automatic wait_rst(input logic v, input int maxc, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.qpllreset_out !== v && n < maxc);
  endtask

  task automatic wait_ready(input logic v, input int maxc, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.qpll_ready_out !== v && n < maxc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, f_rst, f_rdy;
    int rises[$];
    logic prev;
    bus.qplllock_in = 0; bus.qpllrefclklost_in = 0; bus.reinit_req_in = 0;
    repeat (3) @(negedge clk);
    check("rst_qpllreset", int'(bus.qpllreset_out), 1);
    check("rst_ready", int'(bus.qpll_ready_out), 0);
    check("rst_retry", int'(bus.retry_count_out), 0);
    check("rst_fault", int'(bus.fault_out), 0);

    // 1: normal bring-up
    rst = 0;
    wait_rst(0, 20, n);
    check("t1_reset_width", n, 4);
    repeat (10) @(negedge clk);
    bus.qplllock_in = 1;
    wait_ready(1, 40, n);
    check("t1_ready_latency", n, 10);
    check("t1_retry", int'(bus.retry_count_out), 0);

    // 4: one-cycle lock drop while LOCKED
    repeat (3) @(negedge clk);
    bus.qplllock_in = 0;
    @(negedge clk);
    bus.qplllock_in = 1;
    wait_ready(0, 10, n);
    check("t4_ready_fall", n + 1, 3);
    check("t4_retry", int'(bus.retry_count_out), 1);
    check("t4_reset_repulse", int'(bus.qpllreset_out), 1);
    wait_ready(1, 60, n);
    check("t4_relock", n, 12);

    // 5: reinit, then glitch lock at stable count 5
    repeat (2) @(negedge clk);
    bus.reinit_req_in = 1;
    f_rdy = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.reinit_req_in = 0;
        check("t5_ready_drop", int'(bus.qpll_ready_out), 0);
      end
      if (i == 9)  bus.qplllock_in = 0;
      if (i == 10) bus.qplllock_in = 1;
      if (bus.qpll_ready_out && f_rdy < 0) f_rdy = i;
    end
    check("t5_ready_after_glitch", f_rdy, 20);
    check("t5_retry", int'(bus.retry_count_out), 1);

    // 6: refclk lost and reinit together while LOCKED
    bus.qpllrefclklost_in = 1;
    bus.reinit_req_in = 1;
    f_rst = -1; f_rdy = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.reinit_req_in = 0;
        check("t6_ready_drop", int'(bus.qpll_ready_out), 0);
      end
      if (i == 6) bus.qpllrefclklost_in = 0;
      if (i > 1 && !bus.qpllreset_out && f_rst < 0) f_rst = i;
      if (bus.qpll_ready_out && f_rdy < 0) f_rdy = i;
    end
    check("t6_reset_release", f_rst, 16);
    check("t6_ready_rise", f_rdy, 24);
    check("t6_retry", int'(bus.retry_count_out), 1);

    // 2/3: lock held low from a fresh reset
    rst = 1;
    bus.qplllock_in = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    prev = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      @(negedge clk);
      if (i == 115) bus.reinit_req_in = 1;
      if (i == 116) bus.reinit_req_in = 0;
      if (bus.qpllreset_out && !prev) rises.push_back(i);
      prev = bus.qpllreset_out;
      if (i == 36)  check("t2_retry_1", int'(bus.retry_count_out), 1);
      if (i == 72)  check("t2_retry_2", int'(bus.retry_count_out), 2);
      if (i == 110) begin
        check("t2_retry_3", int'(bus.retry_count_out), 3);
        check("t3_fault_set", int'(bus.fault_out), int'(LIMIT));
      end
      if (i == 117) check("t3_fault_clear", int'(bus.fault_out), 0);
      if (i == 150) check("t3_retry_hold", int'(bus.retry_count_out), 3);
      if (i == 152) check("t3_retry_4", int'(bus.retry_count_out), 4);
    end
    check("t2_rise_count_min", int'(rises.size() >= 3), 1);
    if (rises.size() >= 3) begin
      check("t2_rise_0", rises[0], 36);
      check("t2_rise_1", rises[1], 72);
      check("t2_rise_2", rises[2], 108);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qeciphy_qpll_reset_ctrl.md
Name: qeciphy_qpll_reset_ctrl

Overview:
- Sequencing controller on the consumer side of the GTX QPLL common block.
- Drives the QPLL reset, watches the QPLL lock and reference-clock-lost status, and qualifies lock stability.
- Retries on timeout or lock loss and reports a single ready flag to the channel reset logic.
- Sits between the top-level reset tree and the QPLL common wrapper; runs on the free-running lock-detect clock.

Parameters:
- RESET_CYCLES, 64, clk_in cycles qpllreset_out is held high per reset attempt (min 2).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024, consecutive cycles of synced lock required before ready.
- MAX_RETRIES, 8, consecutive failed attempts before FAULT (used only with the optional feature).

Ports:
- clk_in  input  1  free-running clock, same as the QPLL lock-detect clock.
- rst_in  input  1  asynchronous, active-high reset.
- qplllock_in  input  1  QPLL lock from the common block; asynchronous to clk_in.
- qpllrefclklost_in  input  1  reference-clock-lost from the common block; asynchronous.
- reinit_req_in  input  1  single-cycle pulse requesting a full re-initialisation.
- qpllreset_out  output  1  to the common block's QPLL reset.
- qpll_ready_out  output  1  QPLL locked and stable.
- retry_count_out  output  8  saturating count of retries since rst_in.
- fault_out  output  1  sticky retry-limit fault.

Behaviour:
- Clock and reset
  - One clock.
  - Reset is asynchronous and active-high.
- Synchronisers
  - qplllock_in and qpllrefclklost_in each pass through a 2-flop synchroniser, reset to 0. lock_s and lost_s are the synchroniser outputs.
  - All decisions use lock_s and lost_s, so input-to-decision latency is 2 cycles.
- Reset values while rst_in is high
  - state=RESET_ASSERT, cycle counter=0.
  - qpllreset_out=1, qpll_ready_out=0, retry_count_out=0, fault_out=0.
- Outputs and counter
  - qpllreset_out=1 only in RESET_ASSERT and REFCLK_WAIT.
  - qpll_ready_out=1 only in LOCKED.
  - All outputs are registered.
  - A single cycle counter is cleared on every state change.
- State RESET_ASSERT
  - After RESET_CYCLES cycles -> WAIT_LOCK.
  - If lost_s=1 -> REFCLK_WAIT instead.
- State REFCLK_WAIT
  - Reset stays held.
  - Once lost_s=0 for RESET_CYCLES consecutive cycles -> RESET_ASSERT with the counter cleared.
  - Does not count as a retry.
- State WAIT_LOCK
  - lock_s=1 -> LOCK_STABLE.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> RESET_ASSERT and retry_count +1.
- State LOCK_STABLE
  - lock_s=0 -> WAIT_LOCK with the counter cleared. The timeout restarts and this is not a retry.
  - lock_s=1 for STABLE_CYCLES consecutive cycles -> LOCKED.
- State LOCKED
  - lock_s=0 -> RESET_ASSERT, retry_count +1, qpll_ready_out drops on the next edge.
- Events valid in every state except FAULT
  - lost_s=1 -> REFCLK_WAIT and qpll_ready_out=0 next cycle.
  - reinit_req_in=1 -> RESET_ASSERT. retry_count_out is not incremented.
- Priority when events coincide in one cycle: lost_s > reinit_req_in > lock/timeout transitions.
- retry_count_out
  - Saturates at 255; no wrap.
  - Cleared only by rst_in.
- Consecutive-failure counter (internal)
  - Increments on the same events as retry_count.
  - Clears on entering LOCKED.

Optional Feature:
- Macro: QECIPHY_QPLL_RETRY_LIMIT_EN.
- When defined:
  - When the consecutive-failure counter reaches MAX_RETRIES, the next transition goes to FAULT instead of RESET_ASSERT.
  - In FAULT: qpllreset_out=1, qpll_ready_out=0, fault_out=1.
  - FAULT ignores lost_s and lock_s; exit is only via rst_in or reinit_req_in.
  - reinit_req_in clears fault_out and the consecutive counter, then goes to RESET_ASSERT.
- When not defined:
  - FAULT is unreachable and fault_out is tied 0.
  - Retries continue indefinitely.

Test Plan (RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3):
1. Release rst_in, raise qplllock_in 10 cycles after qpllreset_out falls -> qpllreset_out high exactly 4 cycles post-reset; qpll_ready_out rises 2+8 cycles after the lock edge; retry_count_out=0.
2. qplllock_in held 0 -> qpllreset_out re-pulses every 4+32 cycles; retry_count_out counts 1,2,3…; fault_out stays 0 without the macro.
3. With QECIPHY_QPLL_RETRY_LIMIT_EN, lock held 0 -> fault_out=1 after the 3rd timeout; a reinit_req_in pulse clears it and restarts the sequence.
4. In LOCKED, drop lock for 1 cycle -> qpll_ready_out falls 3 cycles after the drop; reset re-pulses; retry_count_out +1.
5. In LOCK_STABLE, glitch lock low at stable count 5 -> returns to WAIT_LOCK; ready only after 8 fresh consecutive lock cycles; no retry counted.
6. Assert qpllrefclklost_in and reinit_req_in in the same cycle while LOCKED -> REFCLK_WAIT, reset held for the whole lost period plus 4 cycles after it clears, then a normal lock sequence; retry_count_out unchanged.
